// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset/lock sequencing and system reset release; PLL_SEQ_LOCK_LOSS_COUNT_EN enables lock_loss_count
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RELEASE_DELAY = 64,
    parameter int MAX_RETRIES = 3,
    localparam int RW = MAX_RETRIES > 0 ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic          refclk,
    input  logic          rst,
    input  logic          pll_locked,
    input  logic          sw_reset_req,
    output logic          pll_rst,
    output logic          sys_reset,
    output logic          ready,
    output logic          fail,
    output logic [RW-1:0] retry_count,
    output logic [7:0]    lock_loss_count
);
    localparam int M0 = PLL_RST_CYCLES > LOCK_TIMEOUT ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int M1 = LOCK_STABLE_CYCLES > RELEASE_DELAY ? LOCK_STABLE_CYCLES : RELEASE_DELAY;
    localparam int CW = $clog2((M0 > M1 ? M0 : M1) + 1);

    typedef enum logic [2:0] {S_PLL_RST, S_WAIT_LOCK, S_STABLE, S_RELEASE, S_RUN, S_FAIL} state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    sync;
    logic          locked_sync, inc_retry;

    assign locked_sync = sync[1];

    // Lock loss is tested before terminal count, so it wins in STABLE/RELEASE.
    always_comb begin
        nxt = state;
        inc_retry = 1'b0;
        if (sw_reset_req) nxt = S_PLL_RST;
        else case (state)
            S_PLL_RST: nxt = cnt == CW'(PLL_RST_CYCLES - 1) ? S_WAIT_LOCK : S_PLL_RST;
            S_WAIT_LOCK: begin
                inc_retry = !locked_sync && cnt == CW'(LOCK_TIMEOUT - 1) && retry_count < RW'(MAX_RETRIES);
                nxt = locked_sync ? S_STABLE :
                      cnt != CW'(LOCK_TIMEOUT - 1) ? S_WAIT_LOCK :
                      inc_retry ? S_PLL_RST : S_FAIL;
            end
            S_STABLE: nxt = !locked_sync ? S_WAIT_LOCK : cnt == CW'(LOCK_STABLE_CYCLES - 1) ? S_RELEASE : S_STABLE;
            S_RELEASE: nxt = !locked_sync ? S_PLL_RST : cnt == CW'(RELEASE_DELAY - 1) ? S_RUN : S_RELEASE;
            S_RUN: nxt = locked_sync ? S_RUN : S_PLL_RST;
            default: nxt = S_FAIL;
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state <= S_PLL_RST;
            cnt <= '0;
            sync <= '0;
            pll_rst <= 1'b1;
            sys_reset <= 1'b1;
            ready <= 1'b0;
            fail <= 1'b0;
            retry_count <= '0;
        end else begin
            sync <= {sync[0], pll_locked};
            state <= nxt;
            cnt <= (nxt != state || sw_reset_req) ? '0 : cnt + CW'(1);
            pll_rst <= nxt == S_PLL_RST || nxt == S_FAIL;
            sys_reset <= nxt != S_RUN;
            ready <= nxt == S_RUN;
            fail <= nxt == S_FAIL;
            retry_count <= (sw_reset_req || nxt == S_RUN) ? '0 : retry_count + RW'(inc_retry);
        end
    end

`ifdef PLL_SEQ_LOCK_LOSS_COUNT_EN
    always_ff @(posedge refclk) begin
        if (rst) lock_loss_count <= '0;
        else if (!sw_reset_req && state == S_RUN && !locked_sync && lock_loss_count != 8'hff)
            lock_loss_count <= lock_loss_count + 8'd1;
    end
`else
    assign lock_loss_count = 8'd0;
`endif
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed scenarios plus random lock/sw traffic against a deadline-based reference model
module tb_pll_reset_sequencer;
    localparam int PRC = 4, TO = 32, LSC = 8, RD = 4, MR = 2;
    localparam int PR = 0, WL = 1, ST = 2, RL = 3, RN = 4, FL = 5;
    localparam logic [13:0] RST_VAL = {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00};
`ifdef PLL_SEQ_LOCK_LOSS_COUNT_EN
    localparam int LLC1 = 1;
`else
    localparam int LLC1 = 0;
`endif

    logic       refclk = 1'b0;
    logic       rst = 1'b1, pll_locked = 1'b0, sw_reset_req = 1'b0;
    logic       pll_rst, sys_reset, ready, fail;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_count;
    wire [13:0] dut_out = {pll_rst, sys_reset, ready, fail, retry_count, lock_loss_count};

    int checks = 0, errors = 0, cyc = 0, ph = PR, dl = 0, m_retry = 0, m_llc = 0;
    bit h1 [0:65535];
    bit rh [0:65535];

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(TO), .LOCK_STABLE_CYCLES(LSC),
        .RELEASE_DELAY(RD), .MAX_RETRIES(MR)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .sw_reset_req(sw_reset_req),
        .pll_rst(pll_rst), .sys_reset(sys_reset), .ready(ready), .fail(fail),
        .retry_count(retry_count), .lock_loss_count(lock_loss_count)
    );

    // Each phase records the absolute edge at which it times out; lock is seen two edges late.
    function automatic void model_step();
        bit ls;
        cyc++;
        ls = (cyc >= 2 && !rh[cyc-1]) ? h1[cyc-2] : 1'b0;
        h1[cyc] = rst ? 1'b0 : pll_locked;
        rh[cyc] = rst;
        if (rst) begin
            ph = PR; dl = cyc + PRC; m_retry = 0; m_llc = 0;
        end else if (sw_reset_req) begin
            ph = PR; dl = cyc + PRC; m_retry = 0;
        end else if (ph == PR) begin
            if (cyc == dl) begin ph = WL; dl = cyc + TO; end
        end else if (ph == WL) begin
            if (ls) begin ph = ST; dl = cyc + LSC; end
            else if (cyc == dl) begin
                if (m_retry < MR) begin m_retry++; ph = PR; dl = cyc + PRC; end
                else ph = FL;
            end
        end else if (ph == ST) begin
            if (!ls) begin ph = WL; dl = cyc + TO; end
            else if (cyc == dl) begin ph = RL; dl = cyc + RD; end
        end else if (ph == RL) begin
            if (!ls) begin ph = PR; dl = cyc + PRC; end
            else if (cyc == dl) begin ph = RN; m_retry = 0; end
        end else if (ph == RN) begin
            if (!ls) begin ph = PR; dl = cyc + PRC; if (m_llc < 255) m_llc++; end
        end
    endfunction

    function automatic logic [13:0] exp_out();
        logic [7:0] l;
`ifdef PLL_SEQ_LOCK_LOSS_COUNT_EN
        l = 8'(m_llc);
`else
        l = 8'd0;
`endif
        return {ph == PR || ph == FL, ph != RN, ph == RN, ph == FL, 2'(m_retry), l};
    endfunction

    task automatic tick();
        @(posedge refclk);
        model_step();
        @(negedge refclk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (dut_out !== RST_VAL) begin errors++; $display("FAIL reset_values edge %0d: got %h, expected %h", cyc, dut_out, RST_VAL); end
        end
        rst = 1'b0;
    endtask

    task automatic test_power_up();
        int t_fall = -1, t_rise = -1;
        for (int i = 1; i <= 30; i++) begin
            pll_locked = (i >= 10);
            tick();
            checks++;
            if (dut_out !== exp_out()) begin errors++; $display("FAIL power_up edge %0d: got %h, expected %h", cyc, dut_out, exp_out()); end
            if (t_fall < 0 && !pll_rst) t_fall = i;
            if (t_rise < 0 && ready) t_rise = i;
        end
        checks++;
        if (t_fall != PRC) begin errors++; $display("FAIL pll_rst_fall_edge: got %0d, expected %0d", t_fall, PRC); end
        checks++;
        if (t_rise != 10 + 2 + LSC + RD) begin errors++; $display("FAIL ready_rise_edge: got %0d, expected %0d", t_rise, 10 + 2 + LSC + RD); end
        checks++;
        if (retry_count !== 2'd0) begin errors++; $display("FAIL power_up_retry: got %0d, expected 0", retry_count); end
    endtask

    task automatic test_stable_glitch();
        int t_rise = -1;
        bit rst_seen = 0;
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        checks++;
        if ({pll_rst, sys_reset, ready} !== 3'b110) begin errors++; $display("FAIL sw_req_next_edge: got %b, expected 110", {pll_rst, sys_reset, ready}); end
        for (int i = 1; i <= 30; i++) begin
            pll_locked = (i != 8);
            tick();
            checks++;
            if (dut_out !== exp_out()) begin errors++; $display("FAIL stable_glitch edge %0d: got %h, expected %h", cyc, dut_out, exp_out()); end
            if (i >= PRC && pll_rst) rst_seen = 1;
            if (t_rise < 0 && ready) t_rise = i;
        end
        checks++;
        if (rst_seen) begin errors++; $display("FAIL glitch_no_pll_rst: got 1, expected 0"); end
        checks++;
        if (t_rise != 23) begin errors++; $display("FAIL glitch_ready_edge: got %0d, expected 23", t_rise); end
        checks++;
        if (retry_count !== 2'd0) begin errors++; $display("FAIL glitch_retry: got %0d, expected 0", retry_count); end
    endtask

    task automatic test_lock_timeout();
        int pulses = 1, w = 1, t_fail = -1;
        int rseq[$];
        logic prev, last_rc;
        logic [1:0] rc;
        sw_reset_req = 1'b1;
        pll_locked = 1'b0;
        tick();
        sw_reset_req = 1'b0;
        prev = pll_rst;
        rc = retry_count;
        last_rc = 1'b0;
        for (int i = 1; i <= 130; i++) begin
            tick();
            checks++;
            if (dut_out !== exp_out()) begin errors++; $display("FAIL lock_timeout edge %0d: got %h, expected %h", cyc, dut_out, exp_out()); end
            if (pll_rst) begin
                if (!prev && !fail) pulses++;
                if (!prev) w = 0;
                w++;
            end else if (prev) begin
                checks++;
                if (w != PRC) begin errors++; $display("FAIL pll_rst_width: got %0d, expected %0d", w, PRC); end
            end
            prev = pll_rst;
            if (retry_count !== rc) begin rc = retry_count; rseq.push_back(int'(rc)); end
            if (t_fail < 0 && fail) t_fail = i;
        end
        checks++;
        if (pulses != 3) begin errors++; $display("FAIL pll_rst_pulses: got %0d, expected 3", pulses); end
        checks++;
        if (rseq.size() != 2 || rseq[0] != 1 || rseq[1] != 2) begin
            errors++; $display("FAIL retry_steps: got %0d values, expected 1 then 2", rseq.size());
        end
        checks++;
        if (t_fail != 3 * PRC + 3 * TO) begin errors++; $display("FAIL fail_edge: got %0d, expected %0d", t_fail, 3 * PRC + 3 * TO); end
        checks++;
        if ({fail, pll_rst, sys_reset, ready} !== 4'b1110) begin errors++; $display("FAIL fail_outputs: got %b, expected 1110", {fail, pll_rst, sys_reset, ready}); end
        if (last_rc) rseq.delete();
    endtask

    task automatic test_sw_from_fail();
        int t_rise = -1;
        pll_locked = 1'b1;
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        checks++;
        if ({fail, pll_rst, retry_count} !== 4'b0100) begin errors++; $display("FAIL sw_exit_fail: got %b, expected 0100", {fail, pll_rst, retry_count}); end
        for (int i = 1; i <= 60; i++) begin
            tick();
            checks++;
            if (dut_out !== exp_out()) begin errors++; $display("FAIL sw_from_fail edge %0d: got %h, expected %h", cyc, dut_out, exp_out()); end
            if (ready) begin t_rise = i; break; end
        end
        checks++;
        if (t_rise != 17) begin errors++; $display("FAIL sw_ready_edge: got %0d, expected 17", t_rise); end
    endtask

    task automatic test_lock_loss_run();
        bit back = 0;
        repeat (3) tick();
        pll_locked = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if ({pll_rst, sys_reset, ready} !== (i < 3 ? 3'b001 : 3'b110)) begin
                errors++; $display("FAIL lock_loss_edge%0d: got %b, expected %b", i, {pll_rst, sys_reset, ready}, (i < 3 ? 3'b001 : 3'b110));
            end
        end
        checks++;
        if (lock_loss_count !== 8'(LLC1)) begin errors++; $display("FAIL lock_loss_count: got %0d, expected %0d", lock_loss_count, LLC1); end
        for (int i = 1; i <= 80; i++) begin
            if (i == 7) pll_locked = 1'b1;
            tick();
            checks++;
            if (dut_out !== exp_out()) begin errors++; $display("FAIL relock edge %0d: got %h, expected %h", cyc, dut_out, exp_out()); end
            if (ready) begin back = 1; break; end
        end
        checks++;
        if (!back) begin errors++; $display("FAIL relock_timeout: got ready=0, expected 1"); end
    endtask

    task automatic test_rst_mid_release();
        bit back = 0;
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            checks++;
            if (dut_out !== exp_out()) begin errors++; $display("FAIL to_release edge %0d: got %h, expected %h", cyc, dut_out, exp_out()); end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dut_out !== RST_VAL) begin errors++; $display("FAIL rst_mid_release: got %h, expected %h", dut_out, RST_VAL); end
        for (int i = 1; i <= 60; i++) begin
            tick();
            checks++;
            if (dut_out !== exp_out()) begin errors++; $display("FAIL after_rst edge %0d: got %h, expected %h", cyc, dut_out, exp_out()); end
            if (ready) begin back = 1; break; end
        end
        checks++;
        if (!back) begin errors++; $display("FAIL after_rst_timeout: got ready=0, expected 1"); end
    endtask

    task automatic test_random();
        int seg = 0;
        for (int i = 0; i < 3000; i++) begin
            if (seg == 0) begin
                pll_locked = ~pll_locked;
                seg = pll_locked ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 50));
            end
            seg--;
            sw_reset_req = ($urandom_range(0, 199) == 0);
            rst = ($urandom_range(0, 999) == 0);
            tick();
            checks++;
            if (dut_out !== exp_out()) begin errors++; $display("FAIL random edge %0d: got %h, expected %h", cyc, dut_out, exp_out()); end
        end
        rst = 1'b0;
        sw_reset_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_stable_glitch();
        test_lock_timeout();
        test_sw_from_fail();
        test_lock_loss_run();
        test_rst_mid_release();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sequences the clock PLL (50 MHz reference in, 143 MHz system/SDRAM clocks out) and the reset of everything it clocks. Runs on the reference clock: pulses the PLL reset, waits for a stable lock with timeout and bounded retries, then releases the system reset after a settle delay. It re-runs the sequence on lock loss or software request, and reports ready/fail status to the board-level logic.

## Interface
Parameters:
- PLL_RST_CYCLES, 16: cycles pll_rst is held high per attempt (≥1)
- LOCK_TIMEOUT, 65535: cycles allowed in WAIT_LOCK before an attempt fails
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required
- RELEASE_DELAY, 64: cycles between stable lock and sys_reset release
- MAX_RETRIES, 3: PLL re-reset attempts after the first before FAIL

Ports:
- refclk  in  1  50 MHz reference clock; the only clock
- rst  in  1  reset, synchronous, active-high
- pll_locked  in  1  PLL lock flag, asynchronous to refclk
- sw_reset_req  in  1  one-cycle request to re-run the full sequence
- pll_rst  out  1  PLL reset, active-high
- sys_reset  out  1  downstream system reset, active-high
- ready  out  1  high only in RUN
- fail  out  1  high only in FAIL
- retry_count  out  clog2(MAX_RETRIES+1)  retries used in the current sequence
- lock_loss_count  out  8  saturating count of lock losses seen in RUN

## Operation
- pll_locked passes through a 2-flop synchronizer. All decisions use locked_sync.
- States: PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL. One shared cycle counter is cleared on every state entry.
- PLL_RST: pll_rst=1. After PLL_RST_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK: if locked_sync=1, go to STABLE. If LOCK_TIMEOUT cycles elapse first:
  - retry_count<MAX_RETRIES: increment retry_count, go to PLL_RST.
  - otherwise: go to FAIL.
- STABLE: if locked_sync=0, go back to WAIT_LOCK (timeout restarts). After LOCK_STABLE_CYCLES consecutive high cycles, go to RELEASE.
- RELEASE: if locked_sync=0, go to PLL_RST (no retry increment). After RELEASE_DELAY cycles, go to RUN.
- RUN: sys_reset=0, ready=1, retry_count cleared. If locked_sync=0, go to PLL_RST and increment lock_loss_count (saturates at 255).
- FAIL: pll_rst=1, sys_reset=1, fail=1. Exits only on rst or sw_reset_req.
- sw_reset_req in any state: go to PLL_RST and clear retry_count. It has priority over every other transition in the same cycle. lock_loss_count is not incremented by it.
- sys_reset=1 in every state except RUN. pll_rst=1 only in PLL_RST and FAIL.
- Simultaneous lock loss and counter terminal count in STABLE/RELEASE: lock loss wins.

## Timing
- Reset values, all registered:
  - Outputs: pll_rst=1, sys_reset=1, ready=0, fail=0, retry_count=0, lock_loss_count=0.
  - Internal: state=PLL_RST, counter=0, synchronizer=0.
- rst asserted mid-operation forces the reset values on the next edge, regardless of state.
- After rst deasserts, pll_rst stays high for exactly PLL_RST_CYCLES edges, then falls.
- Let E be the first edge at which synchronizer stage 1 captures pll_locked=1, with lock held steady. Then sys_reset falls, and ready rises, at edge E+2+LOCK_STABLE_CYCLES+RELEASE_DELAY.
- Lock loss in RUN: sys_reset, ready and pll_rst go high 3 edges after pll_locked falls (2 sync + 1 register).
- sw_reset_req: outputs reflect PLL_RST on the next edge.

## Configuration
- PLL_SEQ_LOCK_LOSS_COUNT_EN defined: lock_loss_count is implemented as specified.
- Undefined: the lock_loss_count port remains but is tied to 0, and its counter is not synthesized. All other behaviour is identical.

## Test plan
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE_CYCLES=8, RELEASE_DELAY=4, MAX_RETRIES=2.
- Power-up, pll_locked first sampled high at edge 10 -> pll_rst high edges 1–4; sys_reset falls and ready rises at edge 24; retry_count=0.
- One-cycle pll_locked drop during STABLE -> stable count restarts; sys_reset release is delayed; no pll_rst pulse; retry_count unchanged.
- pll_locked held low -> three pll_rst pulses of 4 cycles each; retry_count steps 1, then 2; fail=1 after the third timeout; pll_rst and sys_reset stay high.
- In RUN, pll_locked falls -> sys_reset and pll_rst high 3 edges later; lock_loss_count=1; sequence re-runs; ready returns when lock does.
- sw_reset_req pulsed in FAIL, lock available -> fail=0 next edge; retry_count=0; full sequence completes to RUN.
- rst pulsed mid-RELEASE; also, with the macro undefined, a lock loss in RUN -> all outputs at reset values next edge; lock_loss_count stays 0.
